// File: rtl/bcm_sym_packer_if.sv
// Symbol-in / word-out handshake bundle for the symbol packer.
// Signal names match the packer's port list.
interface bcm_sym_packer_if #(
  parameter int SYM_W = 2,
  parameter int N_SYM = 4,
  parameter int CNT_W = $clog2(N_SYM) + 1
);
  logic                     in_valid;
  logic [SYM_W-1:0]         in_sym;
  logic                     in_ready;
  logic                     flush;
  logic                     out_valid;
  logic [SYM_W*N_SYM-1:0]   out_word;
  logic [CNT_W-1:0]         out_cnt;
  logic                     out_ready;

  modport master (
    output in_valid, in_sym, flush, out_ready,
    input  in_ready, out_valid, out_word, out_cnt
  );

  modport slave (
    input  in_valid, in_sym, flush, out_ready,
    output in_ready, out_valid, out_word, out_cnt
  );
endinterface

// File: rtl/bcm_sym_packer.sv
// Packs N_SYM converter symbols per word, first symbol in the LSBs.
// One-entry registered output; flush emits a partial word with its count.
module bcm_sym_packer #(
  parameter int SYM_W = 2,
  parameter int N_SYM = 4,
  parameter int CNT_W = $clog2(N_SYM) + 1
) (
  input logic             clk,
  input logic             rst_b,
  bcm_sym_packer_if.slave bus
);
  localparam int WW = SYM_W * N_SYM;

  typedef enum logic [1:0] {
    COLLECT,
    FULL,
    FLUSH_PEND
  } state_t;

  state_t           state, state_n;
  logic [WW-1:0]    acc, acc_n, full_word;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             flush_pend, fp_n;
  logic             out_valid;
  logic [WW-1:0]    out_word;
  logic [CNT_W-1:0] out_cnt;
  logic             in_ready;
  logic             slot_free;
  logic             load;
  logic [WW-1:0]    ld_word;
  logic [CNT_W-1:0] ld_cnt;

  assign slot_free = ~out_valid | bus.out_ready;

  always_comb begin
    full_word = acc;
    full_word[(N_SYM-1)*SYM_W +: SYM_W] = bus.in_sym;
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    fp_n     = flush_pend;
    load     = 1'b0;
    ld_word  = acc;
    ld_cnt   = cnt;
    in_ready = 1'b0;
    unique case (state)
      COLLECT: begin
        in_ready = ~bus.flush & ~flush_pend;
        if (bus.flush) begin
          // A flush on an empty accumulator has nothing to emit.
          if (cnt != '0) begin
            if (slot_free) begin
              load  = 1'b1;
              acc_n = '0;
              cnt_n = '0;
            end else begin
              fp_n    = 1'b1;
              state_n = FLUSH_PEND;
            end
          end
        end else if (bus.in_valid) begin
          if (cnt < CNT_W'(N_SYM - 1)) begin
            for (int k = 0; k < N_SYM - 1; k++) begin
              if (cnt == CNT_W'(k)) acc_n[k*SYM_W +: SYM_W] = bus.in_sym;
            end
            cnt_n = cnt + 1'b1;
          end else if (slot_free) begin
            load    = 1'b1;
            ld_word = full_word;
            ld_cnt  = CNT_W'(N_SYM);
            acc_n   = '0;
            cnt_n   = '0;
          end else begin
            acc_n   = full_word;
            cnt_n   = CNT_W'(N_SYM);
            state_n = FULL;
          end
        end
      end
      FULL: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_cnt  = CNT_W'(N_SYM);
          acc_n   = '0;
          cnt_n   = '0;
          state_n = COLLECT;
        end
      end
      FLUSH_PEND: begin
        if (slot_free) begin
          load    = 1'b1;
          acc_n   = '0;
          cnt_n   = '0;
          fp_n    = 1'b0;
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= COLLECT;
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      flush_pend <= fp_n;
    end
  end

  // Load wins over a plain drain, giving back-to-back words without a bubble.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_cnt   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_word  <= ld_word;
      out_cnt   <= ld_cnt;
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_word  = out_word;
  assign bus.out_cnt   = out_cnt;
endmodule
